// File: rtl/axis_row_producer_pkg.sv
// Shared constants for the AXI-Stream row producer: packet types, lane masks,
// default row length and FSM state codes.
package axis_producer_pkg;

  localparam logic [7:0] PKT_HEADER  = 8'h00;
  localparam logic [7:0] PKT_AXI_REQ = 8'h01;  // reserved, never emitted here
  localparam logic [7:0] PKT_TRAILER = 8'h02;

  // Index k selects the mask applied to lane k mod 4.
  localparam logic [3:0][31:0] LANE_MASK = {32'h5555_5555, 32'hAAAA_AAAA,
                                            32'hFFFF_FFFF, 32'h0000_0000};

  localparam int DATA_CYCLES = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_TRAILER = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

endpackage

// File: rtl/axis_row_producer_if.sv
// AXI-Stream bundle between the row producer and its consumer.
interface axis_row_producer_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TVALID;
  logic                  TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/axis_row_producer_pattern.sv
// Data-beat pattern: every 32-bit lane is the seed XORed with a per-lane mask.
module row_pattern_gen #(
  parameter int DATA_WIDTH = 512
) (
  input  logic [31:0]           i_seed,
  input  logic                  i_inject,
  output logic [DATA_WIDTH-1:0] o_data
);
  import axis_producer_pkg::*;

  localparam int NUM_LANES = DATA_WIDTH / 32;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    // Error injection flips only lane 1 bit 0.
    logic [31:0] w_flip;
    assign w_flip = (k == 1) ? {31'b0, i_inject} : 32'b0;
    assign o_data[32*k +: 32] = i_seed ^ LANE_MASK[k % 4] ^ w_flip;
  end

endmodule

// File: rtl/axis_row_producer.sv
// Streams row_count rows of header / DATA_CYCLES data / trailer beats with an
// optional idle gap between rows.
module axis_row_producer #(
  parameter int DATA_WIDTH  = 512,
  parameter int DATA_CYCLES = axis_producer_pkg::DATA_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] row_count,
  input  logic [15:0] gap_cycles,
  input  logic        inject_error,
  output logic        busy,
  output logic        done,
  output logic [63:0] rows_sent,
  axis_row_producer_if.master AXIS_OUT
);
  import axis_producer_pkg::*;

  localparam int BW = $clog2(DATA_CYCLES + 1);

  logic [2:0]            r_state;
  logic [63:0]           r_row_idx;
  logic [63:0]           r_rows_total;
  logic [63:0]           r_rows_sent;
  logic [15:0]           r_gap;
  logic [15:0]           r_gap_cnt;
  logic [BW-1:0]         r_beat;
  logic [31:0]           r_seed;
  logic                  r_inject;
  logic                  r_done;

  logic                  w_tvalid;
  logic                  w_hs;
  logic                  w_last_beat;
  logic                  w_last_row;
  logic                  w_inject_now;
  logic [DATA_WIDTH-1:0] w_pattern;
  logic [DATA_WIDTH-1:0] w_tdata;

  assign w_tvalid     = (r_state == ST_HEADER) || (r_state == ST_DATA) ||
                        (r_state == ST_TRAILER);
  assign w_hs         = w_tvalid && AXIS_OUT.TREADY;
  assign w_last_beat  = (r_beat == BW'(DATA_CYCLES - 1));
  assign w_last_row   = (r_row_idx == r_rows_total - 64'd1);
  assign w_inject_now = r_inject && (r_row_idx == 64'd0) && (r_beat == '0);

  row_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
    .i_seed   (r_seed),
    .i_inject (w_inject_now),
    .o_data   (w_pattern)
  );

  // TDATA is decoded from registers that only move on a handshake, so it
  // holds steady through back-pressure and drops to zero with reset.
  always_comb begin
    w_tdata = '0;
    case (r_state)
      ST_HEADER:  w_tdata = {PKT_HEADER, {(DATA_WIDTH-72){1'b0}}, r_row_idx};
      ST_DATA:    w_tdata = w_pattern;
      ST_TRAILER: w_tdata = {PKT_TRAILER, {(DATA_WIDTH-72){1'b0}}, r_row_idx};
      default:    w_tdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_row_idx    <= '0;
      r_rows_total <= '0;
      r_rows_sent  <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_beat       <= '0;
      r_seed       <= '0;
      r_inject     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rows_total <= row_count;
            r_gap        <= gap_cycles;
            r_inject     <= inject_error;
            r_row_idx    <= '0;
            r_rows_sent  <= '0;
            r_seed       <= '0;
            r_beat       <= '0;
            if (row_count != 64'd0) r_state <= ST_HEADER;
            else                    r_done  <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (w_hs) begin
            r_beat  <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            r_seed <= r_seed + 32'd1;
            r_beat <= r_beat + BW'(1);
            if (w_last_beat) r_state <= ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (w_hs) begin
            r_rows_sent <= r_rows_sent + 64'd1;
            if (w_last_row) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_row_idx <= r_row_idx + 64'd1;
              if (r_gap != 16'd0) begin
                r_gap_cnt <= r_gap;
                r_state   <= ST_GAP;
              end else begin
                r_state <= ST_HEADER;
              end
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 16'd1) r_state <= ST_HEADER;
          else                    r_gap_cnt <= r_gap_cnt - 16'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign AXIS_OUT.TDATA  = w_tdata;
  assign AXIS_OUT.TVALID = w_tvalid;
  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;
  assign rows_sent       = r_rows_sent;

endmodule

// File: tb/tb_axis_row_producer.sv
// Scenario bench for axis_row_producer against a row/beat list model.
module tb_axis_row_producer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] row_count = '0;
  logic [15:0] gap_cycles = '0;
  logic        inject_error = 1'b0;
  logic        busy, done;
  logic [63:0] rows_sent;

  axis_row_producer_if #(.DATA_WIDTH(512)) axis ();

  axis_row_producer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .row_count    (row_count),
    .gap_cycles   (gap_cycles),
    .inject_error (inject_error),
    .busy         (busy),
    .done         (done),
    .rows_sent    (rows_sent),
    .AXIS_OUT     (axis)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [511:0] got_data[$];
  int           got_cyc[$];
  logic [511:0] exp_q[$];
  int           done_cyc;
  int           done_cnt;
  int           stall_err;
  int           busy_at_done;
  bit           rnd_ready;

  // Expected stream: rows of header, DATA beats with a running seed, trailer.
  function automatic logic [511:0] model_data(int unsigned seed, bit flip);
    logic [31:0]  masks[4];
    logic [511:0] w;
    masks = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555};
    for (int k = 0; k < 16; k++) w[32*k +: 32] = seed ^ masks[k % 4];
    if (flip) w[32] = ~w[32];
    return w;
  endfunction

  function automatic logic [511:0] model_marker(logic [7:0] typ, longint unsigned row);
    logic [511:0] w;
    w = '0;
    w[511:504] = typ;
    w[63:0] = row;
    return w;
  endfunction

  function automatic void build_expected(int rows, bit inj);
    int unsigned seed;
    seed = 0;
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      exp_q.push_back(model_marker(8'h00, r));
      for (int b = 0; b < 32; b++) begin
        exp_q.push_back(model_data(seed, inj && r == 0 && b == 0));
        seed++;
      end
      exp_q.push_back(model_marker(8'h02, r));
    end
  endfunction

  function automatic int first_mismatch();
    int n;
    n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_data[i] !== exp_q[i]) return i;
    if (got_data.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Runs one dataset and records accepted beats, done timing and stall holds.
  task automatic run_ds(input logic [63:0] rows, input logic [15:0] gap, input bit inj,
                        input int restart_cyc, input int max_cyc);
    logic [511:0] prev_d;
    bit           prev_stall;
    got_data.delete(); got_cyc.delete();
    done_cyc = -1; done_cnt = 0; stall_err = 0; busy_at_done = 0;
    prev_stall = 0; prev_d = '0;
    @(posedge clk); #1;
    start = 1'b1; row_count = rows; gap_cycles = gap; inject_error = inj;
    axis.TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = (c == restart_cyc);
        if (c == restart_cyc) row_count = 64'd5;
        axis.TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #3;
      if (prev_stall && (axis.TVALID !== 1'b1 || axis.TDATA !== prev_d)) stall_err++;
      if (axis.TVALID === 1'b1 && axis.TREADY) begin
        got_data.push_back(axis.TDATA);
        got_cyc.push_back(c);
      end
      prev_stall = (axis.TVALID === 1'b1) && !axis.TREADY;
      prev_d = axis.TDATA;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        if (busy !== 1'b0) busy_at_done++;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0; inject_error = 1'b0;
    axis.TREADY = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (axis.TVALID !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: tvalid=%b busy=%b done=%b, want 0 0 0", axis.TVALID, busy, done);
    end
    n_chk++;
    if (rows_sent !== 64'd0 || axis.TDATA !== 512'd0) begin
      n_fail++;
      $display("FAIL reset_data: rows_sent=%0d tdata=%h, want 0", rows_sent, axis.TDATA);
    end
    // Start presented together with deassertion is taken on the very next edge.
    reset = 1'b0; start = 1'b1; row_count = 64'd0;
    @(posedge clk); #1;
    start = 1'b0;
    #3;
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_start: done=%b, want 1", done);
    end
  endtask

  task automatic test_single_row();
    rnd_ready = 0;
    run_ds(64'd1, 16'd0, 1'b0, -1, 100);
    build_expected(1, 0);
    n_chk++;
    if (first_mismatch() !== -1) begin
      n_fail++;
      $display("FAIL single_beats: mismatch at beat %0d of %0d got", first_mismatch(), got_data.size());
    end
    n_chk++;
    if (got_cyc.size() < 34 || got_cyc[0] !== 1 || got_cyc[1] !== 2 ||
        got_cyc[32] !== 33 || got_cyc[33] !== 34) begin
      n_fail++;
      $display("FAIL single_timing: %0d beats, header/data0/trailer cycles wrong, want 1/2/34",
               got_cyc.size());
    end
    n_chk++;
    if (done_cyc !== 35 || done_cnt !== 1 || busy_at_done !== 0) begin
      n_fail++;
      $display("FAIL single_done: cycle=%0d count=%0d busy_hi=%0d, want 35 1 0",
               done_cyc, done_cnt, busy_at_done);
    end
    n_chk++;
    if (got_data.size() < 2 ||
        got_data[1][127:0] !== {32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0}) begin
      n_fail++;
      $display("FAIL single_lanes: got %h, want 55555555aaaaaaaaffffffff00000000",
               got_data.size() > 1 ? got_data[1][127:0] : 128'hx);
    end
    n_chk++;
    if (rows_sent !== 64'd1) begin
      n_fail++;
      $display("FAIL single_rows_sent: got %0d want 1", rows_sent);
    end
  endtask

  task automatic test_random_ready();
    rnd_ready = 1;
    run_ds(64'd2, 16'd0, 1'b0, -1, 600);
    rnd_ready = 0;
    build_expected(2, 0);
    n_chk++;
    if (got_data.size() !== 68 || first_mismatch() !== -1) begin
      n_fail++;
      $display("FAIL stall_beats: got %0d beats, first mismatch %0d, want 68 and none",
               got_data.size(), first_mismatch());
    end
    n_chk++;
    if (stall_err !== 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d unstable stall cycles, want 0", stall_err);
    end
    n_chk++;
    if (rows_sent !== 64'd2 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL stall_done: rows_sent=%0d done_cnt=%0d, want 2 1", rows_sent, done_cnt);
    end
  endtask

  task automatic test_gap();
    rnd_ready = 0;
    run_ds(64'd3, 16'd5, 1'b0, -1, 300);
    build_expected(3, 0);
    n_chk++;
    if (first_mismatch() !== -1) begin
      n_fail++;
      $display("FAIL gap_beats: mismatch at beat %0d", first_mismatch());
    end
    n_chk++;
    if (got_cyc.size() < 102 || got_cyc[34] - got_cyc[33] !== 6 || got_cyc[68] - got_cyc[67] !== 6) begin
      n_fail++;
      $display("FAIL gap_length: %0d beats, trailer-to-header spacing wrong, want 6", got_cyc.size());
    end
    n_chk++;
    if (got_cyc.size() < 102 || done_cyc !== got_cyc[101] + 1) begin
      n_fail++;
      $display("FAIL gap_done: done at %0d, want cycle after last trailer", done_cyc);
    end
  endtask

  task automatic test_zero_rows();
    rnd_ready = 0;
    run_ds(64'd0, 16'd3, 1'b0, -1, 20);
    n_chk++;
    if (done_cyc !== 1 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL zero_done: cycle=%0d count=%0d, want 1 1", done_cyc, done_cnt);
    end
    n_chk++;
    if (got_data.size() !== 0 || rows_sent !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_stream: beats=%0d rows_sent=%0d, want 0 0", got_data.size(), rows_sent);
    end
  endtask

  task automatic test_inject();
    int errs;
    rnd_ready = 0;
    run_ds(64'd1, 16'd0, 1'b1, -1, 100);
    build_expected(1, 1);
    n_chk++;
    if (first_mismatch() !== -1) begin
      n_fail++;
      $display("FAIL inject_beats: mismatch at beat %0d", first_mismatch());
    end
    n_chk++;
    if (got_data.size() < 2 || got_data[1][63:32] !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL inject_lane1: got %h want fffffffe",
               got_data.size() > 1 ? got_data[1][63:32] : 32'hx);
    end
    build_expected(1, 0);
    errs = 0;
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      if (got_data[i] !== exp_q[i]) errs++;
    n_chk++;
    if (errs !== 1) begin
      n_fail++;
      $display("FAIL inject_count: %0d corrupted words, want 1", errs);
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    start = 1'b1; row_count = 64'd2; gap_cycles = 16'd0; axis.TREADY = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    n_chk++;
    if (axis.TVALID !== 1'b1 || axis.TDATA !== model_data(10, 0)) begin
      n_fail++;
      $display("FAIL midrst_pre: tvalid=%b lane0=%h, want 1 0000000a", axis.TVALID, axis.TDATA[31:0]);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (axis.TVALID !== 1'b0 || busy !== 1'b0 || rows_sent !== 64'd0 || axis.TDATA !== 512'd0) begin
      n_fail++;
      $display("FAIL midrst_clear: tvalid=%b busy=%b rows_sent=%0d, want 0 0 0",
               axis.TVALID, busy, rows_sent);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rnd_ready = 0;
    run_ds(64'd1, 16'd0, 1'b0, -1, 100);
    build_expected(1, 0);
    n_chk++;
    if (first_mismatch() !== -1 || rows_sent !== 64'd1) begin
      n_fail++;
      $display("FAIL midrst_restart: mismatch at beat %0d rows_sent=%0d, want none 1",
               first_mismatch(), rows_sent);
    end
  endtask

  task automatic test_busy_ignore();
    rnd_ready = 0;
    run_ds(64'd1, 16'd0, 1'b0, 5, 120);
    build_expected(1, 0);
    n_chk++;
    if (first_mismatch() !== -1 || rows_sent !== 64'd1 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL busy_ignore: beats=%0d rows_sent=%0d done_cnt=%0d, want 34 1 1",
               got_data.size(), rows_sent, done_cnt);
    end
  endtask

  task automatic test_random_rows();
    int rows;
    int gap;
    int low_ok;
    rows = $urandom_range(1, 3);
    gap = $urandom_range(0, 4);
    rnd_ready = 1;
    run_ds(64'(rows), 16'(gap), 1'b0, -1, 1200);
    rnd_ready = 0;
    build_expected(rows, 0);
    n_chk++;
    if (first_mismatch() !== -1 || stall_err !== 0) begin
      n_fail++;
      $display("FAIL random_rows: rows=%0d gap=%0d mismatch at %0d stall_err=%0d",
               rows, gap, first_mismatch(), stall_err);
    end
    low_ok = 1;
    for (int r = 1; r < rows; r++)
      if (got_cyc.size() >= 34 * rows && got_cyc[34*r] - got_cyc[34*r-1] < gap + 1) low_ok = 0;
    n_chk++;
    if (low_ok !== 1 || rows_sent !== 64'(rows)) begin
      n_fail++;
      $display("FAIL random_gap: spacing_ok=%0d rows_sent=%0d, want 1 %0d", low_ok, rows_sent, rows);
    end
  endtask

  initial begin
    axis.TREADY = 1'b1;
    rnd_ready = 0;
    test_reset();
    test_single_row();
    test_random_ready();
    test_gap();
    test_zero_rows();
    test_inject();
    test_mid_reset();
    test_busy_ignore();
    repeat (3) test_random_rows();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_row_producer.md
AXIS_ROW_PRODUCER -- requirements
Module: axis_row_producer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 512, stream width; only 512 is supported.
REQ-002 The block SHALL have parameter DATA_CYCLES, default 32, data beats per row.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, single-cycle pulse that begins a dataset.
REQ-006 The block SHALL have port row_count, input, 64, number of rows in the dataset, sampled on start.
REQ-007 The block SHALL have port gap_cycles, input, 16, idle cycles between rows, sampled on start.
REQ-008 The block SHALL have port inject_error, input, 1, corrupt one data word when high on start.
REQ-009 The block SHALL have port busy, output, 1, dataset in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse when the dataset completes.
REQ-011 The block SHALL have port rows_sent, output, 64, count of trailer beats accepted.
REQ-012 The block SHALL have ports AXIS_OUT_TDATA (output, 512), AXIS_OUT_TVALID (output, 1) and AXIS_OUT_TREADY (input, 1), the AXI-Stream master.

Function
REQ-013 The block SHALL emit each row as 1 header beat, then DATA_CYCLES data beats, then 1 trailer beat.
REQ-014 The header SHALL carry TDATA[511:504]=8'h00, TDATA[63:0]=row index (0-based), and zeros elsewhere.
REQ-015 The trailer SHALL carry TDATA[511:504]=8'h02, TDATA[63:0]=row index, and zeros elsewhere.
REQ-016 In each data beat, lane k (TDATA[32k+31:32k], k=0..15) SHALL equal seed XOR mask[k mod 4], where masks are 0, FFFF_FFFF, AAAA_AAAA, 5555_5555.
REQ-017 The 32-bit seed SHALL clear on start, increment by 1 after each accepted data beat across rows, and wrap at 2^32.
REQ-018 A beat SHALL transfer only when TVALID and TREADY are both high; TDATA and TVALID SHALL hold stable while TVALID=1 and TREADY=0.
REQ-019 The block SHALL use the states IDLE, HEADER, DATA, TRAILER, GAP.
REQ-020 The IDLE state SHALL go to HEADER on start when row_count is nonzero; otherwise it stays IDLE and pulses done in the next cycle.
REQ-021 The HEADER state SHALL go to DATA on handshake.
REQ-022 The DATA state SHALL go to TRAILER on the handshake of data beat DATA_CYCLES.
REQ-023 After the trailer handshake, the block SHALL go to IDLE if that was the last row, else to GAP if gap_cycles is nonzero, else to HEADER.
REQ-024 The GAP state SHALL hold TVALID=0 for exactly gap_cycles cycles, then go to HEADER.
REQ-025 Latency: the header TVALID SHALL rise the cycle after start; with gap_cycles=0 and TREADY=1, rows SHALL be back-to-back with no bubble.
REQ-026 rows_sent SHALL clear on start and increment on each trailer handshake.
REQ-027 done SHALL pulse the cycle after the last trailer handshake, and busy SHALL fall in that same cycle.
REQ-028 A start received while busy=1 SHALL be ignored.
REQ-029 With inject_error sampled high, the first data beat of row 0 SHALL have lane 1 bit 0 inverted; all other beats SHALL be unaffected.
REQ-030 The row index SHALL be 64 bits wide with no wrap within the row_count range.

Reset
REQ-031 On reset assertion, the block SHALL immediately return to IDLE with TVALID=0, busy=0, done=0, rows_sent=0, seed=0 and TDATA=0.
REQ-032 A reset mid-row SHALL abandon the row; no trailer is sent and no partial count is retained.
REQ-033 The block SHALL accept start on the first clock edge after reset deasserts.

Structure
REQ-034 Package axis_producer_pkg SHALL hold the packet-type constants (8'h00 header, 8'h01 AXI request (reserved), 8'h02 trailer), the four lane masks, DATA_CYCLES and the state enumeration.
REQ-035 Sub-module row_pattern_gen SHALL map (seed, inject flag) to the 512-bit data word; the state machine and counters SHALL remain in axis_row_producer.

Verification
REQ-036 Scenario: row_count=1, gap=0, TREADY=1, start at cycle 0 -> header at cycle 1, data beats at cycles 2-33, trailer at cycle 34, done at cycle 35; first data beat lanes 0-3 are 0, FFFF_FFFF, AAAA_AAAA, 5555_5555; rows_sent=1.
REQ-037 Scenario: row_count=2 with random TREADY -> TDATA stable across every stall; seeds run 0..63 with no gaps; 68 beats total.
REQ-038 Scenario: row_count=3, gap=5 -> exactly 5 TVALID-low cycles after each of the first two trailers, and none after the third; done follows the third trailer.
REQ-039 Scenario: row_count=0 -> done pulses at cycle 1, TVALID never rises, rows_sent=0.
REQ-040 Scenario: inject_error=1, row_count=1 -> first data beat lane 1 = FFFF_FFFE; every other word matches REQ-016 (a downstream checker counts exactly 1 error).
REQ-041 Scenario: reset during data beat 10 -> TVALID=0 before the next edge, busy=0, rows_sent=0; a new start restarts at row 0 with seed 0.
